// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional parity/stop framing, one status pulse per frame.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote around mid-bit.
module uart_rx #(
    parameter int width      = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             Par_en,
    input  logic             Par_type,
    output logic [width-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stop_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (width > 1) ? $clog2(width) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = OVERSAMPLE / 2 + 1;
`else
    localparam int SAMPLE_AT = OVERSAMPLE / 2;
`endif
    localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_AT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_idx_q, bit_idx_d;
    logic [width-1:0]   shift_q, shift_d;
    logic [width-1:0]   p_data_q, p_data_d;
    logic               par_en_q, par_en_d;
    logic               par_type_q, par_type_d;
    logic               perr_q, perr_d;
    logic               dv_q, dv_d;
    logic               pe_q, pe_d;
    logic               se_q, se_d;
    logic               sync1_q, rx_s;
    logic               rx_bit;
    logic               sample_pt;

`ifdef UART_RX_MAJORITY_EN
    logic s0_q, s1_q;

    // The two earlier votes are captured one and two clocks before the decision point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (cnt_q == CW'(SAMPLE_AT - 2)) s0_q <= rx_s;
            if (cnt_q == CW'(SAMPLE_AT - 1)) s1_q <= rx_s;
        end
    end

    assign rx_bit = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    assign sample_pt  = (cnt_q == CNT_SAMPLE);
    assign P_data     = p_data_q;
    assign Data_valid = dv_q;
    assign Par_err    = pe_q;
    assign Stop_err   = se_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rx_s       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            perr_q     <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            rx_s       <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            perr_q     <= perr_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    // Stop is evaluated half a bit early so the next start edge is never missed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        perr_d     = perr_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d    = START;
                    par_en_d   = Par_en;
                    par_type_d = Par_type;
                    perr_d     = 1'b0;
                end
            end
            START: begin
                if (sample_pt && rx_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (sample_pt) shift_d = {rx_bit, shift_q[width-1:1]};
                if (cnt_q == CNT_LAST) begin
                    if (bit_idx_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                    else bit_idx_d = bit_idx_q + BW'(1);
                end
            end
            PARITY: begin
                if (sample_pt && (rx_bit != ((^shift_q) ^ par_type_q))) perr_d = 1'b1;
                if (cnt_q == CNT_LAST) state_d = STOP;
            end
            STOP: begin
                if (sample_pt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!rx_bit) se_d = 1'b1;
                    else if (perr_q) pe_d = 1'b1;
                    else begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected status/data queued per frame, checked on each output pulse.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic       Par_en = 1'b0;
    logic       Par_type = 1'b0;
    logic [7:0] P_data;
    logic       Data_valid, Par_err, Stop_err;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] lastGood = 8'h00;
    int         nCompared = 0;
    int         nMismatched = 0;

    uart_rx #(.width(8), .OVERSAMPLE(8)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Par_en(Par_en), .Par_type(Par_type),
        .P_data(P_data), .Data_valid(Data_valid), .Par_err(Par_err), .Stop_err(Stop_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Every cycle with a status pulse consumes one scoreboard entry; a 2-cycle pulse shows up as spurious.
    always @(negedge clk) begin
        if (!rst && (Data_valid || Par_err || Stop_err)) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_pulse", {Stop_err, Par_err, Data_valid}, 3'b000);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("pulse_kind", {Stop_err, Par_err, Data_valid}, e.kind);
                checkOutput("p_data", P_data, e.data);
            end
        end
    end

    task automatic holdBit(input logic b, input int glitchAt);
        for (int i = 0; i < 8; i++) begin
            RX_IN = (i == glitchAt) ? ~b : b;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // glitchBit selects a data bit that gets a one-clock inversion at the mid-bit sample.
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                 input logic badPar, input logic stopBit,
                                 input logic flipCfg, input int glitchBit);
        exp_t e;
        if (!stopBit) begin
            e.kind = 3'b100; e.data = lastGood;
        end else if (pe && badPar) begin
            e.kind = 3'b010; e.data = lastGood;
        end else begin
            e.kind = 3'b001; e.data = d; lastGood = d;
        end
        sbq.push_back(e);
        Par_en = pe;
        Par_type = pt;
        holdBit(1'b0, -1);
        if (flipCfg) begin
            Par_en = ~pe;
            Par_type = ~pt;
        end
        for (int b = 0; b < 8; b++) holdBit(d[b], (b == glitchBit) ? 5 : -1);
        if (pe) holdBit(((^d) ^ pt) ^ badPar, -1);
        holdBit(stopBit, -1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_p_data", P_data, 8'h00);
        checkOutput("rst_data_valid", Data_valid, 1'b0);
        checkOutput("rst_par_err", Par_err, 1'b0);
        checkOutput("rst_stop_err", Stop_err, 1'b0);
        rst = 1'b0;
        idle(5);

        applyStimulus(8'hA5, 0, 0, 0, 1, 0, -1);
        idle(4);
        applyStimulus(8'h3C, 1, 0, 0, 1, 0, -1);
        idle(4);
        applyStimulus(8'h3C, 1, 0, 1, 1, 0, -1);
        idle(4);
        applyStimulus(8'h96, 1, 1, 0, 1, 0, -1);
        idle(4);
        applyStimulus(8'h71, 0, 0, 0, 1, 1, -1);
        idle(4);
        applyStimulus(8'h55, 0, 0, 0, 0, 0, -1);
        idle(16);
        applyStimulus(8'h81, 0, 0, 0, 1, 0, -1);

        // Short low glitch must be rejected as a false start.
        RX_IN = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        idle(20);

        applyStimulus(8'h00, 0, 0, 0, 1, 0, -1);
        applyStimulus(8'hFF, 0, 0, 0, 1, 0, -1);
        applyStimulus(8'h5A, 0, 0, 0, 1, 0, -1);
        idle(4);
`ifdef UART_RX_MAJORITY_EN
        applyStimulus(8'hB4, 0, 0, 0, 1, 0, 2);
        idle(4);
`endif

        // Abort 0x0F partway through bit 3 with reset.
        Par_en = 1'b0;
        holdBit(1'b0, -1);
        holdBit(1'b1, -1);
        holdBit(1'b1, -1);
        holdBit(1'b1, -1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        RX_IN = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("midrst_p_data", P_data, 8'h00);
        checkOutput("midrst_pulses", {Stop_err, Par_err, Data_valid}, 3'b000);
        rst = 1'b0;
        lastGood = 8'h00;
        idle(20);
        applyStimulus(8'hC3, 0, 0, 0, 1, 0, -1);
        idle(40);

        checkOutput("scoreboard_drained", sbq.size(), 0);
        checkOutput("final_p_data", P_data, 8'hC3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link; the downstream stage that consumes the serial line driven by the UART transmitter. Oversamples `RX_IN` and recovers start/data/parity/stop framing. Delivers each good byte as a one-cycle `Data_valid` pulse with `P_data`, and flags parity and framing errors. Frame format matches the transmitter: 1 start bit (0), WIDTH data bits LSB first, optional parity bit, 1 stop bit (1).

## Interface
- `width`, 8, data bits per frame.
- `OVERSAMPLE`, 8, clk cycles per bit; even, ≥4.
- `clk`  input  1  receive clock, OVERSAMPLE × bit rate.
- `rst`  input  1  asynchronous, active-high reset.
- `RX_IN`  input  1  serial line; idle high; asynchronous to clk.
- `Par_en`  input  1  1 = frame carries a parity bit.
- `Par_type`  input  1  0 = even parity, 1 = odd parity.
- `P_data`  output  width  last good received word.
- `Data_valid`  output  1  one-cycle pulse: `P_data` updated.
- `Par_err`  output  1  one-cycle pulse: parity mismatch.
- `Stop_err`  output  1  one-cycle pulse: stop bit sampled 0.

## Operation
- `RX_IN` passes a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `cnt` counts 0..OVERSAMPLE-1 and wraps.
  - `bit_idx` counts 0..width-1.
- IDLE, `rx_s`==0:
  - Enter START; `cnt`←0.
  - Latch `Par_en` and `Par_type`; changes after this point are ignored for the frame.
- Sample point is `cnt`==OVERSAMPLE/2. Bit value is the sampled value (see Configuration).
- START:
  - Sample 1 at the sample point → false start, return to IDLE.
  - Otherwise, at `cnt`==OVERSAMPLE-1 → DATA, `bit_idx`←0.
- DATA:
  - Sample shifts into a shift register, LSB first.
  - At `cnt`==OVERSAMPLE-1: if `bit_idx`==width-1, go to PARITY if parity is latched, else STOP; otherwise `bit_idx`++.
- PARITY:
  - Sampled bit is compared with XOR(data) for even parity, ~XOR(data) for odd.
  - Mismatch latches an internal error flag.
  - At `cnt`==OVERSAMPLE-1 → STOP.
- STOP, at the sample point, return to IDLE immediately (half-bit early, to allow resync) and evaluate the frame:
  - Stop bit 0 → `Stop_err` pulse.
  - Else parity flag set → `Par_err` pulse.
  - Else `P_data`←shift register and `Data_valid` pulse.
- Only one output pulse per frame. `Stop_err` has priority over `Par_err`. `P_data` is unchanged on any error.
- After a stop error the FSM returns to IDLE. If the line is still low, it re-detects a start immediately (break condition); this is acceptable.

## Timing
- Reset values: `P_data`=0, `Data_valid`=0, `Par_err`=0, `Stop_err`=0. FSM in IDLE, counters 0, synchronizer 1.
- Start detection cycle T0 is 2 clks after `RX_IN` first falls (synchronizer delay).
- Frame has N = width+2 (+1 with parity) bit slots. The stop sample occurs (N-1)·OVERSAMPLE + OVERSAMPLE/2 clks after T0.
- The status pulse (`Data_valid`/`Par_err`/`Stop_err`) is registered. It is high for exactly the one clk following the stop sample edge.
- `P_data` changes in the same cycle `Data_valid` rises and holds until the next good frame.
- Back-to-back frames with zero idle time are received without loss.
- `rst` asserted mid-frame: all state and outputs return to reset values immediately, with no pulse. After release, reception restarts only on a fresh falling edge of `rx_s`.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Bit value = majority of 3 samples at `cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
  - The decision is still taken at `cnt`==OVERSAMPLE/2+1. All sample points, and the stop-sample timing above, shift by +1 clk.
- Undefined: single sample at `cnt`==OVERSAMPLE/2. No extra registers.

## Test plan
- No parity. Frame 0xA5 (width 8, OVERSAMPLE 8), each bit held 8 clks → one `Data_valid` pulse at T0+76, `P_data`=0xA5, no error pulses.
- Even parity, `Par_en`=1 `Par_type`=0. Frame 0x3C with parity bit 0 → `Data_valid`, `P_data`=0x3C. Same frame with parity bit 1 → `Par_err` pulse only, `P_data` keeps its previous value.
- Stop error. Frame 0x55 with stop bit driven 0 → `Stop_err` pulse, no `Data_valid`. A following good frame 0x81 is received correctly.
- Glitch rejection. `RX_IN` low for 2 clks, then high → no pulse, FSM back in IDLE. With `UART_RX_MAJORITY_EN`, a 1-clk glitch inside a data bit at `cnt`==4 does not corrupt the byte.
- Back-to-back. Frames 0x00, 0xFF, 0x5A with no idle gap → three `Data_valid` pulses, correct data.
- Reset mid-frame. Assert `rst` during bit 3 of 0x0F, release, then send 0xC3 → no pulse for the aborted frame, then `P_data`=0xC3.
